// File: rtl/lcd_pkg.sv
// lcd_pkg
// Shared defaults for the LCD scanout path: panel geometry, pixel type,
// the colour shown when scanout runs dry, and a frame-size helper.
package lcd_pkg;

   localparam int LCD_SCREEN_WIDTH  = 800;
   localparam int LCD_SCREEN_HEIGHT = 480;
   localparam int LCD_DATA_W        = 16;

   // Number of pixels in one frame at the default geometry
   localparam int LCD_FRAME_SIZE = LCD_SCREEN_WIDTH * LCD_SCREEN_HEIGHT;

   // One RGB565 pixel
   typedef logic [LCD_DATA_W-1:0] pixel_t;

   // Solid red makes a starved scanout obvious on the panel
   localparam pixel_t LCD_UNDERRUN_COLOR = 16'hF800;

   // Frame size for a given geometry, used by the arbiter to stop fetching
   function automatic int lcd_frame_size(input int width, input int height);
      return width * height;
   endfunction

endpackage

// File: rtl/lcd_pix_fifo.sv
// lcd_pix_fifo
// Small synchronous prefetch FIFO between the framebuffer read port and the
// pixel output register. Flush has priority over push and pop. A pop on an
// empty FIFO is ignored. A push on a full FIFO is accepted only when a pop
// happens in the same cycle, so occupancy stays the same. The read data is
// the head entry, shown combinationally.
module lcd_pix_fifo #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              push,
   input  logic              pop,
   input  logic              flush,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout,
   output logic              full,
   output logic              empty,
   output logic [CNT_W-1:0]  count
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              do_push;
   logic              do_pop;

   // Qualify push/pop against the current occupancy and expose status flags
   always_comb begin
      full    = (count == CNT_W'(DEPTH));
      empty   = (count == '0);
      do_pop  = pop && !empty;
      do_push = push && (!full || do_pop);
      dout    = mem[rd_ptr];
   end

   // Storage array; it needs no reset because count tells us what is valid
   always_ff @(posedge CLK) begin
      if (do_push && !flush) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointer and occupancy bookkeeping, cleared by reset or flush
   always_ff @(posedge CLK) begin
      if (RST || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/lcd_scan_arbiter.sv
// lcd_scan_arbiter
// Shares one single-port framebuffer between LCD scanout and a host writer.
// Scanout prefetch has fixed priority: whenever the prefetch FIFO plus any read
// in flight has room, the frame is not finished, and we are outside vertical
// sync, the cycle goes to a read. Otherwise a pending host write is granted.
// Pixel and sync strobes are registered together so they stay aligned.
// Optional feature macro: LCD_ARB_UNDERRUN_CNT_EN adds a saturating 16-bit
// underrun pixel counter on port UNDERRUN_CNT.
module lcd_scan_arbiter
   import lcd_pkg::*;
#(
   parameter int SCREEN_WIDTH  = LCD_SCREEN_WIDTH,
   parameter int SCREEN_HEIGHT = LCD_SCREEN_HEIGHT,
   parameter int ADDR_W        = 19,
   parameter int DATA_W        = LCD_DATA_W,
   parameter int FIFO_DEPTH    = 4,
   parameter logic [DATA_W-1:0] UNDERRUN_COLOR = DATA_W'(LCD_UNDERRUN_COLOR)
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              DE_IN,
   input  logic              HSYNC_IN,
   input  logic              VSYNC_IN,
   output logic [ADDR_W-1:0] MEM_ADDR,
   output logic              MEM_RD,
   output logic              MEM_WR,
   output logic [DATA_W-1:0] MEM_WDATA,
   input  logic [DATA_W-1:0] MEM_RDATA,
   input  logic              HOST_REQ,
   input  logic [ADDR_W-1:0] HOST_ADDR,
   input  logic [DATA_W-1:0] HOST_WDATA,
   output logic              HOST_ACK,
   output logic [DATA_W-1:0] PIXEL,
   output logic              DE_OUT,
   output logic              HSYNC_OUT,
   output logic              VSYNC_OUT,
   output logic              UNDERRUN
`ifdef LCD_ARB_UNDERRUN_CNT_EN
   ,
   output logic [15:0]       UNDERRUN_CNT
`endif
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam logic [ADDR_W:0] FRAME_SIZE =
      (ADDR_W+1)'(lcd_frame_size(SCREEN_WIDTH, SCREEN_HEIGHT));
   localparam logic [CNT_W:0] LVL_MAX = (CNT_W+1)'(FIFO_DEPTH);

   logic [ADDR_W-1:0] fptr;
   logic              in_flight;
   logic [CNT_W:0]    lvl;
   logic              fetch_ok;
   logic              rd_grant;
   logic              wr_grant;

   logic              fifo_push;
   logic              fifo_pop;
   logic [DATA_W-1:0] fifo_dout;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CNT_W-1:0]  fifo_count;

   // Returning read data enters the FIFO unless vertical sync discards it;
   // every DE cycle tries to pop, and vertical sync empties the FIFO
   assign fifo_push = in_flight && !VSYNC_IN;
   assign fifo_pop  = DE_IN;

   lcd_pix_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .CLK   (CLK),
      .RST   (RST),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .flush (VSYNC_IN),
      .din   (MEM_RDATA),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Fixed-priority grant: prefetch first, then host, and nothing while in reset
   always_comb begin
      lvl       = {1'b0, fifo_count} + {{CNT_W{1'b0}}, in_flight};
      fetch_ok  = !RST && !VSYNC_IN && !fifo_full && (lvl < LVL_MAX)
                  && ({1'b0, fptr} < FRAME_SIZE);
      rd_grant  = fetch_ok;
      wr_grant  = !RST && !fetch_ok && HOST_REQ;
      MEM_RD    = rd_grant;
      MEM_WR    = wr_grant;
      HOST_ACK  = wr_grant;
      MEM_ADDR  = '0;
      MEM_WDATA = '0;
      if (rd_grant) begin
         MEM_ADDR = fptr;
      end else if (wr_grant) begin
         MEM_ADDR  = HOST_ADDR;
         MEM_WDATA = HOST_WDATA;
      end
   end

   // Fetch pointer walks the frame once and parks at the end until vertical sync
   always_ff @(posedge CLK) begin
      if (RST || VSYNC_IN) begin
         fptr <= '0;
      end else if (rd_grant) begin
         fptr <= fptr + ADDR_W'(1);
      end
   end

   // Remember that a read was issued so its data is pushed next cycle
   always_ff @(posedge CLK) begin
      if (RST) begin
         in_flight <= 1'b0;
      end else begin
         in_flight <= rd_grant;
      end
   end

   // Output stage: pixel, delayed strobes and the sticky underrun flag
   always_ff @(posedge CLK) begin
      if (RST) begin
         PIXEL     <= '0;
         DE_OUT    <= 1'b0;
         HSYNC_OUT <= 1'b0;
         VSYNC_OUT <= 1'b0;
         UNDERRUN  <= 1'b0;
      end else begin
         DE_OUT    <= DE_IN;
         HSYNC_OUT <= HSYNC_IN;
         VSYNC_OUT <= VSYNC_IN;
         if (!DE_IN) begin
            PIXEL <= '0;
         end else if (fifo_empty) begin
            PIXEL <= UNDERRUN_COLOR;
         end else begin
            PIXEL <= fifo_dout;
         end
         if (VSYNC_IN) begin
            UNDERRUN <= 1'b0;
         end else if (DE_IN && fifo_empty) begin
            UNDERRUN <= 1'b1;
         end
      end
   end

`ifdef LCD_ARB_UNDERRUN_CNT_EN
   // Count starved pixels per frame, saturating so it never wraps to zero
   always_ff @(posedge CLK) begin
      if (RST || VSYNC_IN) begin
         UNDERRUN_CNT <= '0;
      end else if (DE_IN && fifo_empty && (UNDERRUN_CNT != 16'hFFFF)) begin
         UNDERRUN_CNT <= UNDERRUN_CNT + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_lcd_scan_arbiter.sv
// tb_lcd_scan_arbiter
// Directed bench for lcd_scan_arbiter on a tiny 8x2 panel so the end of the
// frame is reachable quickly. Memory returns its own address as data, so the
// expected pixel stream is simply the sequence of frame addresses.
// Honours LCD_ARB_UNDERRUN_CNT_EN when it is defined.
module tb_lcd_scan_arbiter;

   localparam int W     = 8;
   localparam int H     = 2;
   localparam int AW    = 19;
   localparam int DW    = 16;
   localparam int DEPTH = 4;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          DE_IN = 1'b0;
   logic          HSYNC_IN = 1'b0;
   logic          VSYNC_IN = 1'b0;
   logic [AW-1:0] MEM_ADDR;
   logic          MEM_RD;
   logic          MEM_WR;
   logic [DW-1:0] MEM_WDATA;
   logic [DW-1:0] MEM_RDATA = '0;
   logic          HOST_REQ = 1'b0;
   logic [AW-1:0] HOST_ADDR = '0;
   logic [DW-1:0] HOST_WDATA = '0;
   logic          HOST_ACK;
   logic [DW-1:0] PIXEL;
   logic          DE_OUT;
   logic          HSYNC_OUT;
   logic          VSYNC_OUT;
   logic          UNDERRUN;
`ifdef LCD_ARB_UNDERRUN_CNT_EN
   logic [15:0]   UNDERRUN_CNT;
`endif

   int checks = 0;
   int errors = 0;

   lcd_scan_arbiter #(
      .SCREEN_WIDTH  (W),
      .SCREEN_HEIGHT (H),
      .ADDR_W        (AW),
      .DATA_W        (DW),
      .FIFO_DEPTH    (DEPTH),
      .UNDERRUN_COLOR(16'hF800)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .DE_IN      (DE_IN),
      .HSYNC_IN   (HSYNC_IN),
      .VSYNC_IN   (VSYNC_IN),
      .MEM_ADDR   (MEM_ADDR),
      .MEM_RD     (MEM_RD),
      .MEM_WR     (MEM_WR),
      .MEM_WDATA  (MEM_WDATA),
      .MEM_RDATA  (MEM_RDATA),
      .HOST_REQ   (HOST_REQ),
      .HOST_ADDR  (HOST_ADDR),
      .HOST_WDATA (HOST_WDATA),
      .HOST_ACK   (HOST_ACK),
      .PIXEL      (PIXEL),
      .DE_OUT     (DE_OUT),
      .HSYNC_OUT  (HSYNC_OUT),
      .VSYNC_OUT  (VSYNC_OUT),
      .UNDERRUN   (UNDERRUN)
`ifdef LCD_ARB_UNDERRUN_CNT_EN
      ,
      .UNDERRUN_CNT (UNDERRUN_CNT)
`endif
   );

   // Free-running pixel clock
   always #5 CLK = ~CLK;

   // Framebuffer model: a read returns its own address one cycle later
   always @(posedge CLK) begin
      MEM_RDATA <= MEM_RD ? MEM_ADDR[DW-1:0] : 16'hDEAD;
   end

   // One cycle: wait for the edge, drive new inputs, let logic settle
   task automatic applyStimulus(input logic rst, input logic de, input logic hs,
                                input logic vs, input logic req,
                                input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
      @(posedge CLK);
      #1;
      RST        = rst;
      DE_IN      = de;
      HSYNC_IN   = hs;
      VSYNC_IN   = vs;
      HOST_REQ   = req;
      HOST_ADDR  = addr;
      HOST_WDATA = wdata;
      #1;
   endtask

   task automatic idle();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   initial begin
      $display("[TB] reset and mid-fill reset");
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
      checkOutput("rst_mem_rd", MEM_RD, 0);
      checkOutput("rst_mem_wr", MEM_WR, 0);
      checkOutput("rst_mem_addr", MEM_ADDR, 0);
      checkOutput("rst_mem_wdata", MEM_WDATA, 0);
      checkOutput("rst_host_ack", HOST_ACK, 0);
      checkOutput("rst_pixel", PIXEL, 0);
      checkOutput("rst_de_out", DE_OUT, 0);
      checkOutput("rst_vsync_out", VSYNC_OUT, 0);
      checkOutput("rst_underrun", UNDERRUN, 0);

      // Fill: reads to addresses 0..3 on consecutive cycles
      for (int i = 0; i < 4; i++) begin
         idle();
         checkOutput("fill_rd", MEM_RD, 1);
         checkOutput("fill_addr", MEM_ADDR, i);
      end
      // Three entries stored, one read in flight: reset now
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 19'h00055, 16'h5555);
      checkOutput("rst_gate_rd", MEM_RD, 0);
      checkOutput("rst_gate_ack", HOST_ACK, 0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
      checkOutput("rst_fifo_count", dut.u_fifo.count, 0);
      checkOutput("rst_in_flight", dut.in_flight, 0);
      checkOutput("rst_mid_addr", MEM_ADDR, 0);
      idle();
      checkOutput("post_rst_rd", MEM_RD, 1);
      checkOutput("post_rst_addr", MEM_ADDR, 0);

      $display("[TB] vsync then one full line, host waits");
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
      checkOutput("vs_no_rd", MEM_RD, 0);
      checkOutput("vs_out", VSYNC_OUT, 1);
      for (int i = 0; i < 6; i++) begin
         idle();
      end
      checkOutput("full_count", dut.u_fifo.count, DEPTH);
      for (int i = 0; i < W; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, (i >= 1), 19'h01234, 16'hBEEF);
         if (i >= 1) begin
            checkOutput("line0_pixel", PIXEL, i - 1);
            checkOutput("line0_de_out", DE_OUT, 1);
            checkOutput("line0_host_blocked", HOST_ACK, 0);
         end
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 19'h01234, 16'hBEEF);
      checkOutput("line0_last_pixel", PIXEL, 7);
      checkOutput("line0_underrun", UNDERRUN, 0);
      checkOutput("blank_fetch_rd", MEM_RD, 1);
      checkOutput("blank_fetch_addr", MEM_ADDR, 11);
      checkOutput("blank_no_ack", HOST_ACK, 0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 19'h01234, 16'hBEEF);
      checkOutput("host_ack", HOST_ACK, 1);
      checkOutput("host_wr", MEM_WR, 1);
      checkOutput("host_no_rd", MEM_RD, 0);
      checkOutput("host_addr", MEM_ADDR, 19'h01234);
      checkOutput("host_wdata", MEM_WDATA, 16'hBEEF);
      checkOutput("blank_pixel", PIXEL, 0);
      checkOutput("blank_de_out", DE_OUT, 0);
      idle();
      checkOutput("idle_wr", MEM_WR, 0);
      checkOutput("idle_ack", HOST_ACK, 0);

      $display("[TB] second line reaches end of frame");
      for (int i = 0; i < W; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, (i >= 5), AW'(100 + i), DW'(16'hA000 + i));
         if (i >= 1) begin
            checkOutput("line1_pixel", PIXEL, 8 + i - 1);
         end
         if (i == 4) begin
            checkOutput("last_fetch_addr", MEM_ADDR, W * H - 1);
         end
         if (i >= 5) begin
            checkOutput("eof_no_rd", MEM_RD, 0);
            checkOutput("eof_host_ack", HOST_ACK, 1);
            checkOutput("eof_host_addr", MEM_ADDR, 100 + i);
         end
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 19'd200, 16'h1111);
      checkOutput("line1_last_pixel", PIXEL, 15);
      checkOutput("line1_underrun", UNDERRUN, 0);
      checkOutput("eof_blank_ack", HOST_ACK, 1);
      checkOutput("eof_blank_rd", MEM_RD, 0);
      checkOutput("eof_blank_wdata", MEM_WDATA, 16'h1111);

      $display("[TB] DE straight after vsync underruns");
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, '0, '0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
      checkOutput("sync_vs_out", VSYNC_OUT, 1);
      checkOutput("sync_hs_out", HSYNC_OUT, 1);
      checkOutput("newframe_rd", MEM_RD, 1);
      checkOutput("newframe_addr", MEM_ADDR, 0);
      idle();
      checkOutput("under_pixel", PIXEL, 16'hF800);
      checkOutput("under_de_out", DE_OUT, 1);
      checkOutput("under_flag", UNDERRUN, 1);
`ifdef LCD_ARB_UNDERRUN_CNT_EN
      checkOutput("under_cnt", UNDERRUN_CNT, 1);
`endif
      idle();
      checkOutput("under_sticky", UNDERRUN, 1);
      checkOutput("under_hs_low", HSYNC_OUT, 0);

      $display("[TB] vsync clears underrun, push and pop at lvl max");
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
      idle();
      checkOutput("vs_clear_underrun", UNDERRUN, 0);
`ifdef LCD_ARB_UNDERRUN_CNT_EN
      checkOutput("vs_clear_cnt", UNDERRUN_CNT, 0);
`endif
      idle();
      idle();
      idle();
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
      checkOutput("lvl_max_no_rd", MEM_RD, 0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
      checkOutput("pushpop_count", dut.u_fifo.count, 3);
      checkOutput("pushpop_pixel0", PIXEL, 0);
      idle();
      checkOutput("pushpop_pixel1", PIXEL, 1);
      idle();
      checkOutput("pushpop_tail", PIXEL, 0);
      checkOutput("pushpop_underrun", UNDERRUN, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/lcd_scan_arbiter.md
# lcd_scan_arbiter

Shares one single-port pixel memory between LCD scanout and a host writer. Sits between the LCD timing generator (consumes its DE/HSYNC/VSYNC) and the framebuffer RAM. Keeps a small prefetch FIFO full so DE cycles always have a pixel, and grants idle memory cycles to host writes. Emits pixel data plus sync/DE strobes delayed one cycle so they stay aligned with the pixel.

## Interface
Parameters:
- SCREEN_WIDTH, 800, active pixels per line
- SCREEN_HEIGHT, 480, active lines per frame
- ADDR_W, 19, memory address width (must hold SCREEN_WIDTH*SCREEN_HEIGHT-1)
- DATA_W, 16, pixel width (RGB565)
- FIFO_DEPTH, 4, prefetch FIFO entries (power of two, ≥2)
- UNDERRUN_COLOR, 16'hF800, pixel driven on underrun

Ports (one clock; reset is synchronous and active-high):
- CLK  in  1  pixel clock
- RST  in  1  synchronous active-high reset
- DE_IN  in  1  active-area strobe from timing generator
- HSYNC_IN  in  1  from timing generator
- VSYNC_IN  in  1  from timing generator; 1 = vertical sync interval
- MEM_ADDR  out  ADDR_W  memory address
- MEM_RD  out  1  read strobe; data returns next cycle
- MEM_WR  out  1  write strobe
- MEM_WDATA  out  DATA_W  write data
- MEM_RDATA  in  DATA_W  read data, valid the cycle after MEM_RD
- HOST_REQ  in  1  host write request, held until ack
- HOST_ADDR  in  ADDR_W  host write address
- HOST_WDATA  in  DATA_W  host write data
- HOST_ACK  out  1  one-cycle pulse: write performed this cycle
- PIXEL  out  DATA_W  registered pixel
- DE_OUT, HSYNC_OUT, VSYNC_OUT  out  1 each  inputs delayed one cycle
- UNDERRUN  out  1  sticky; set on any underrun, cleared by reset or VSYNC_IN=1

## Operation
- Fetch pointer FPTR (ADDR_W bits) counts 0..SCREEN_WIDTH*SCREEN_HEIGHT-1, no wrap; stops at end of frame.
- Level LVL = FIFO occupancy + reads in flight (0 or 1). Fetch eligible when LVL < FIFO_DEPTH, FPTR < frame size, VSYNC_IN=0.
- Arbitration per cycle, fixed priority: eligible fetch → MEM_RD=1, MEM_ADDR=FPTR, FPTR+1; else HOST_REQ → MEM_WR=1, MEM_ADDR=HOST_ADDR, MEM_WDATA=HOST_WDATA, HOST_ACK=1; else idle (MEM_RD=MEM_WR=0). MEM_RD and MEM_WR are never both 1.
- Read data pushed into FIFO the cycle after MEM_RD.
- Each cycle DE_IN=1: if FIFO non-empty, pop → PIXEL; else PIXEL=UNDERRUN_COLOR, UNDERRUN set, no pop. No push-to-pop bypass: pop on empty with same-cycle push is an underrun.
- DE_IN=0: PIXEL=0.
- VSYNC_IN=1: FPTR=0, FIFO flushed, in-flight read discarded, UNDERRUN cleared; host writes still granted. Realigns after underrun.
- Reset: FPTR=0, FIFO empty, no read in flight; all outputs 0 (MEM_ADDR, MEM_WDATA, PIXEL included).

## Timing
- DE_IN at cycle t → PIXEL/DE_OUT valid t+1; HSYNC_OUT/VSYNC_OUT = inputs delayed 1.
- Fetch-to-pixel minimum 2 cycles (RD t, push t+1, pop t+2).
- Steady DE: one fetch per cycle → host starves during active lines; host bandwidth only in blanking or once the FIFO is full.
- HOST_ACK combinational from grant, same cycle as MEM_WR; host must drop/change HOST_REQ the cycle after ack.
- Simultaneous push and pop on a full FIFO: legal, occupancy unchanged.

## Configuration
- LCD_ARB_UNDERRUN_CNT_EN defined: adds output UNDERRUN_CNT [15:0], counts underrun pixels, saturates at 16'hFFFF, cleared by reset and VSYNC_IN=1.
- Undefined: port and counter absent; sticky UNDERRUN only.

## Structure
- Package lcd_pkg: SCREEN_WIDTH/SCREEN_HEIGHT defaults, pixel typedef (DATA_W), UNDERRUN_COLOR default, frame-size constant.
- Sub-module lcd_pix_fifo: synchronous FIFO (push, pop, flush, full, empty, count); arbiter holds FPTR, in-flight flag, grant logic, output registers.

## Test plan
- Reset mid-frame with FIFO full and read in flight → next cycle all outputs 0, FIFO empty, first post-reset fetch addr 0.
- VSYNC then 800 consecutive DE cycles, memory returns data=addr → PIXEL sequence 0..799 starting one cycle after first DE, UNDERRUN=0.
- HOST_REQ held during active line → no HOST_ACK while fetches eligible; ack granted within FIFO_DEPTH cycles after DE falls, MEM_WR with correct addr/data.
- DE asserted 1 cycle after VSYNC ends (FIFO empty) → first PIXEL=16'hF800, UNDERRUN=1; cleared by next VSYNC; with LCD_ARB_UNDERRUN_CNT_EN, UNDERRUN_CNT=1.
- FPTR reaches 384000 → MEM_RD stays 0, host gets every cycle until VSYNC.
- Full FIFO, DE and returning read same cycle → no overflow, no dropped pixel, occupancy unchanged.
